xm23_pic: RTL and testbench
===========================

Name: xm23_pic

Overview:
- Priority interrupt controller for the XM23 CPU.
- Latches device interrupt requests and arbitrates among them by programmable priority.
- Offers one interrupt at a time to the control unit, supplying the vector number and the new priority used for the vector fetch, then acknowledges the winning device.
- Sits between peripherals and the control unit's pic_in/pic_read handshake.

Parameters:
NUM_SRC, 8, number of interrupt sources; fixed at 8 so that cfg_idx is 3 bits.
VECT_W, 4, vector number width; matches the CPU's 16-entry vector table.
PRI_W, 3, priority width; matches the PSW current-priority field.

Ports:
Clock  in  1  system clock; all state updates on the rising edge.
Reset  in  1  synchronous, active-high reset.
dev_req  in  NUM_SRC  level interrupt request per device.
cfg_we  in  1  configuration write strobe.
cfg_idx  in  3  source index being configured.
cfg_en  in  1  enable bit written to source cfg_idx.
cfg_pri  in  PRI_W  priority written to source cfg_idx.
cfg_vect  in  VECT_W  vector number written to source cfg_idx.
curr_pri  in  PRI_W  CPU current priority from PSW bits 7:5.
pic_read  in  1  CPU accepts the offered interrupt (single-cycle pulse).
irq_pending  out  1  interrupt offered to the CPU.
vect_num  out  VECT_W  vector of the offered interrupt.
irq_pri  out  PRI_W  priority of the offered interrupt (the CPU's new priority).
dev_ack  out  NUM_SRC  one-hot, one-cycle acknowledge to the serviced device.
pend  out  NUM_SRC  pending-latch status, for debug and LEDs.

Behaviour:
Reset:
- pend=0, req_prev=0, all enables=0, all priorities=0, vector[i]=i.
- FSM=IDLE, irq_pending=0, vect_num=0, irq_pri=0, dev_ack=0.
- Reset asserted in any state returns to IDLE and drops the offer without sending dev_ack.

Configuration:
- On cfg_we, source cfg_idx takes en/pri/vect at that edge.
- Values already latched for an active offer do not change.

Request capture:
- req_prev <= dev_req every cycle.
- pend[i] is set at an edge where dev_req[i]=1, req_prev[i]=0 and en[i]=1.
- Edges on disabled sources are discarded.

Eligibility and arbitration:
- Source i is eligible when pend[i], en[i] and pri[i] > curr_pri (strict). Priority 0 is therefore never offered.
- The winner is the eligible source with the highest pri. On a tie, the lowest index wins.

FSM:
- IDLE
  - Any eligible source: latch win_idx, vect_num=vect[win], irq_pri=pri[win]; go to OFFER.
  - Otherwise stay in IDLE.
- OFFER
  - irq_pending=1; vect_num and irq_pri are held stable.
  - pic_read=1: go to ACK.
  - Else, if the offered source is no longer eligible (curr_pri >= irq_pri, or en cleared): go to IDLE. This is a withdraw; pend is kept.
  - pic_read has precedence over a withdraw in the same cycle.
  - A higher-priority arrival does not replace the current offer. It is arbitrated after return to IDLE.
- ACK
  - irq_pending=0, dev_ack[win_idx]=1 for exactly this cycle, pend[win_idx] cleared.
  - Next state is IDLE.
  - If a new rising edge on win_idx coincides with the ACK clear, set wins and pend stays 1.

Latency:
- dev_req rises before edge E0: pend is set at E0.
- irq_pending goes high after E1 (IDLE->OFFER).
- pic_read at edge Ek gives dev_ack high in cycle k+1.
- Minimum spacing between consecutive offers is 3 cycles: ACK, IDLE, OFFER.

Outputs in IDLE: irq_pending=0, dev_ack=0. vect_num and irq_pri hold their last values.

pic_read outside OFFER is ignored.

Test Plan:
1. Reset, enable src 2 (pri 5, vect 9), curr_pri=3, raise dev_req[2] -> pend=0x04, irq_pending=1 two edges later, vect_num=9, irq_pri=5; pic_read -> dev_ack=0x04 for one cycle, pend=0.
2. Src 1 (pri 4, vect 3) and src 6 (pri 6, vect 12) rise in the same cycle, curr_pri=0 -> src 6 is offered first (vect 12). After ack, src 1 is offered (vect 3, irq_pri 4). Equal priorities 4/4 on src 1 and src 5 -> src 1 wins.
3. Src 0 (pri 2) offered; curr_pri raised to 2 before pic_read -> irq_pending drops, pend[0] stays 1. curr_pri back to 1 -> offer reappears with the same vector.
4. dev_req[3] held high across two acks -> only one pend set (edge detected). Rising edge on src 3 in the ACK cycle of src 3 -> pend[3]=1 after ACK.
5. Disabled src 4 rises, then is enabled -> never pend. Priority-0 source, or pri equal to curr_pri -> irq_pending stays 0.
6. Reset asserted during OFFER with pic_read also high -> no dev_ack, all outputs at reset values at the next edge.

Source files
------------

// File: rtl/xm23_pic.sv
// xm23_pic - priority interrupt controller for the XM23 CPU.
//
// This block latches a rising edge on each enabled device request into a
// pending bit. It offers the highest-priority eligible source to the control
// unit with its vector number and new CPU priority. When the CPU takes the
// offer with pic_read, it pulses a one-hot acknowledge to that device.
//
// FSM states:
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | no offer; arbitrate pending sources each cycle
//   S_OFFER | irq_pending high, vector/priority held for the CPU
//   S_ACK   | one-cycle dev_ack to the winner, its pending bit cleared
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst         synchronous active-high reset
//   i_dev_req     level interrupt request per device
//   i_cfg_we      configuration write strobe
//   i_cfg_idx     source being configured
//   i_cfg_en      enable written to source i_cfg_idx
//   i_cfg_pri     priority written to source i_cfg_idx
//   i_cfg_vect    vector number written to source i_cfg_idx
//   i_curr_pri    CPU current priority (PSW 7:5)
//   i_pic_read    CPU accepts the offered interrupt (pulse)
//   o_irq_pending interrupt offered to the CPU
//   o_vect_num    vector of the offered interrupt
//   o_irq_pri     priority of the offered interrupt
//   o_dev_ack     one-hot, one-cycle acknowledge to the serviced device
//   o_pend        pending-latch status

module xm23_pic #(
  parameter int NUM_SRC = 8,
  parameter int VECT_W  = 4,
  parameter int PRI_W   = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_SRC-1:0] i_dev_req,
  input  logic               i_cfg_we,
  input  logic [2:0]         i_cfg_idx,
  input  logic               i_cfg_en,
  input  logic [PRI_W-1:0]   i_cfg_pri,
  input  logic [VECT_W-1:0]  i_cfg_vect,
  input  logic [PRI_W-1:0]   i_curr_pri,
  input  logic               i_pic_read,
  output logic               o_irq_pending,
  output logic [VECT_W-1:0]  o_vect_num,
  output logic [PRI_W-1:0]   o_irq_pri,
  output logic [NUM_SRC-1:0] o_dev_ack,
  output logic [NUM_SRC-1:0] o_pend
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [NUM_SRC-1:0]  r_req_prev;
  logic [NUM_SRC-1:0]  r_pend;
  logic [NUM_SRC-1:0]  r_en;
  logic [PRI_W-1:0]    r_pri  [NUM_SRC];
  logic [VECT_W-1:0]   r_vect [NUM_SRC];

  logic [2:0]          r_win_idx;
  logic [VECT_W-1:0]   r_vect_num;
  logic [PRI_W-1:0]    r_irq_pri;

  logic [NUM_SRC-1:0]  w_rise;
  logic [NUM_SRC-1:0]  w_elig;
  logic                w_any_elig;
  logic [2:0]          w_best_idx;
  logic [PRI_W-1:0]    w_best_pri;
  logic                w_latch;
  logic [NUM_SRC-1:0]  w_ack_mask;

  // Edges on disabled sources are dropped, not deferred.
  assign w_rise = i_dev_req & ~r_req_prev & r_en;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_elig[i] = r_pend[i] & r_en[i] & (r_pri[i] > i_curr_pri);
    end
  end

  // Ascending scan with strict '>' so the lowest index wins a tie.
  always_comb begin
    w_any_elig = 1'b0;
    w_best_idx = '0;
    w_best_pri = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_elig[i] && (!w_any_elig || (r_pri[i] > w_best_pri))) begin
        w_any_elig = 1'b1;
        w_best_idx = 3'(i);
        w_best_pri = r_pri[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_ack_mask  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any_elig) begin
          w_state_nxt = S_OFFER;
          w_latch     = 1'b1;
        end
      end
      S_OFFER: begin
        // A read in the same cycle as a withdraw condition still completes.
        if (i_pic_read) begin
          w_state_nxt = S_ACK;
        end else if ((i_curr_pri >= r_irq_pri) || !r_en[r_win_idx]) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACK: begin
        w_ack_mask[r_win_idx] = 1'b1;
        w_state_nxt           = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_req_prev <= '0;
      r_pend     <= '0;
      r_en       <= '0;
      r_win_idx  <= '0;
      r_vect_num <= '0;
      r_irq_pri  <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        r_pri[i]  <= '0;
        r_vect[i] <= VECT_W'(i);
      end
    end else begin
      r_req_prev <= i_dev_req;
      // A new edge on the winner in its ACK cycle re-arms the pending bit.
      r_pend     <= (r_pend & ~w_ack_mask) | w_rise;

      if (i_cfg_we) begin
        r_en[i_cfg_idx]   <= i_cfg_en;
        r_pri[i_cfg_idx]  <= i_cfg_pri;
        r_vect[i_cfg_idx] <= i_cfg_vect;
      end

      // Offer contents are captured once and stay put through OFFER/ACK.
      if (w_latch) begin
        r_win_idx  <= w_best_idx;
        r_vect_num <= r_vect[w_best_idx];
        r_irq_pri  <= r_pri[w_best_idx];
      end
    end
  end

  assign o_irq_pending = (r_state == S_OFFER);
  assign o_vect_num    = r_vect_num;
  assign o_irq_pri     = r_irq_pri;
  assign o_dev_ack     = w_ack_mask;
  assign o_pend        = r_pend;

endmodule

// File: tb/tb_xm23_pic.sv
module tb_xm23_pic;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_dev_req = '0;
  logic       i_cfg_we = 1'b0;
  logic [2:0] i_cfg_idx = '0;
  logic       i_cfg_en = 1'b0;
  logic [2:0] i_cfg_pri = '0;
  logic [3:0] i_cfg_vect = '0;
  logic [2:0] i_curr_pri = '0;
  logic       i_pic_read = 1'b0;
  logic       o_irq_pending;
  logic [3:0] o_vect_num;
  logic [2:0] o_irq_pri;
  logic [7:0] o_dev_ack;
  logic [7:0] o_pend;

  xm23_pic #(.NUM_SRC(8), .VECT_W(4), .PRI_W(3)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_dev_req(i_dev_req),
    .i_cfg_we(i_cfg_we), .i_cfg_idx(i_cfg_idx), .i_cfg_en(i_cfg_en),
    .i_cfg_pri(i_cfg_pri), .i_cfg_vect(i_cfg_vect), .i_curr_pri(i_curr_pri),
    .i_pic_read(i_pic_read), .o_irq_pending(o_irq_pending),
    .o_vect_num(o_vect_num), .o_irq_pri(o_irq_pri), .o_dev_ack(o_dev_ack),
    .o_pend(o_pend)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int KOFFER = 1;
  localparam int KACK   = 2;
  localparam int KDROP  = 3;

  typedef struct { int kind; int a; int b; } ev_t;
  ev_t        ev_q[$];
  logic [7:0] pend_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks what the controller should be doing per edge and
  // queues the externally visible events (offer, ack, drop) it predicts.
  int         m_en[8], m_pri[8], m_vect[8];
  bit [7:0]   m_pend, m_prev, m_rise, m_clr;
  int         m_phase;          // 0 nothing offered, 1 offering, 2 acking
  int         m_win, m_opri, m_best;

  initial begin
    m_phase = 0; m_pend = 0; m_prev = 0; m_win = 0; m_opri = 0;
    forever begin
      @(posedge i_clk);
      if (i_rst) begin
        if (m_phase == 1) ev_q.push_back('{KDROP, 0, 0});
        m_phase = 0; m_pend = 0; m_prev = 0; m_opri = 0;
        for (int i = 0; i < 8; i++) begin
          m_en[i] = 0; m_pri[i] = 0; m_vect[i] = i;
        end
      end else begin
        m_rise = 0;
        m_clr  = 0;
        for (int i = 0; i < 8; i++)
          if (i_dev_req[i] && !m_prev[i] && m_en[i] != 0) m_rise[i] = 1;
        if (m_phase == 0) begin
          m_best = -1;
          for (int i = 0; i < 8; i++)
            if (m_pend[i] && m_en[i] != 0 && m_pri[i] > int'(i_curr_pri))
              if (m_best < 0 || m_pri[i] > m_pri[m_best]) m_best = i;
          if (m_best >= 0) begin
            m_phase = 1;
            m_win   = m_best;
            m_opri  = m_pri[m_best];
            ev_q.push_back('{KOFFER, m_vect[m_best], m_pri[m_best]});
          end
        end else if (m_phase == 1) begin
          if (i_pic_read) begin
            m_phase = 2;
            ev_q.push_back('{KACK, 1 << m_win, 0});
          end else if (int'(i_curr_pri) >= m_opri || m_en[m_win] == 0) begin
            m_phase = 0;
            ev_q.push_back('{KDROP, 0, 0});
          end
        end else begin
          m_clr[m_win] = 1;
          m_phase = 0;
        end
        m_pend = (m_pend & ~m_clr) | m_rise;
        if (i_cfg_we) begin
          m_en[i_cfg_idx]   = int'(i_cfg_en);
          m_pri[i_cfg_idx]  = int'(i_cfg_pri);
          m_vect[i_cfg_idx] = int'(i_cfg_vect);
        end
        m_prev = i_dev_req;
      end
      pend_q.push_back(m_pend);
    end
  end

  task automatic expect_ev(input int kind, input int a, input int b);
    ev_t e;
    if (ev_q.size() == 0) begin
      chk("unexpected_event_kind", kind, 0);
    end else begin
      e = ev_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == e.kind && kind == KOFFER) begin
        chk("offer_vect", a, e.a);
        chk("offer_pri", b, e.b);
      end else if (kind == e.kind && kind == KACK) begin
        chk("ack_mask", a, e.a);
      end
    end
  endtask

  // Monitor: samples just after each rising edge and classifies output changes.
  initial begin
    logic       prev_irq;
    logic [7:0] p;
    prev_irq = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      if (pend_q.size() == 0) begin
        chk("pend_queue_underrun", 1, 0);
      end else begin
        p = pend_q.pop_front();
        chk("pend", o_pend, p);
      end
      if (o_dev_ack != 8'h00)
        expect_ev(KACK, int'(o_dev_ack), 0);
      else if (o_irq_pending && !prev_irq)
        expect_ev(KOFFER, int'(o_vect_num), int'(o_irq_pri));
      else if (!o_irq_pending && prev_irq)
        expect_ev(KDROP, 0, 0);
      prev_irq = o_irq_pending;
    end
  end

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) @(negedge i_clk);
  endtask

  task automatic cfg(input int idx, input int en, input int pri, input int vect);
    i_cfg_idx  = 3'(idx);
    i_cfg_en   = 1'(en);
    i_cfg_pri  = 3'(pri);
    i_cfg_vect = 4'(vect);
    i_cfg_we   = 1'b1;
    @(negedge i_clk);
    i_cfg_we   = 1'b0;
  endtask

  task automatic wait_offer(input string nm);
    int n = 0;
    while (!o_irq_pending && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    chk(nm, o_irq_pending, 1);
  endtask

  task automatic do_read();
    i_pic_read = 1'b1;
    @(negedge i_clk);
    i_pic_read = 1'b0;
  endtask

  initial begin
    cyc(3);
    chk("reset_irq", o_irq_pending, 0);
    chk("reset_vect", o_vect_num, 0);
    chk("reset_pri", o_irq_pri, 0);
    chk("reset_ack", o_dev_ack, 0);
    chk("reset_pend", o_pend, 0);
    i_rst = 1'b0;

    // 1: single source, latency and ack
    cfg(2, 1, 5, 9);
    i_curr_pri = 3'd3;
    i_dev_req[2] = 1'b1;
    @(negedge i_clk);
    chk("t1_pend_after_e0", o_pend, 8'h04);
    chk("t1_no_offer_yet", o_irq_pending, 0);
    @(negedge i_clk);
    chk("t1_offer_after_e1", o_irq_pending, 1);
    chk("t1_vect", o_vect_num, 9);
    chk("t1_pri", o_irq_pri, 5);
    do_read();
    chk("t1_ack", o_dev_ack, 8'h04);
    @(negedge i_clk);
    chk("t1_ack_one_cycle", o_dev_ack, 0);
    chk("t1_pend_cleared", o_pend, 0);
    i_dev_req = '0;

    // 2: priority order, then tie on equal priorities
    cfg(1, 1, 4, 3);
    cfg(6, 1, 6, 12);
    i_curr_pri = 3'd0;
    i_dev_req[1] = 1'b1;
    i_dev_req[6] = 1'b1;
    wait_offer("t2_first_offer");
    chk("t2_high_first", o_vect_num, 12);
    do_read();
    wait_offer("t2_second_offer");
    chk("t2_low_vect", o_vect_num, 3);
    chk("t2_low_pri", o_irq_pri, 4);
    do_read();
    i_dev_req = '0;
    @(negedge i_clk);
    cfg(5, 1, 4, 5);
    i_dev_req[1] = 1'b1;
    i_dev_req[5] = 1'b1;
    wait_offer("t2_tie_offer");
    chk("t2_tie_low_index", o_vect_num, 3);
    do_read();
    wait_offer("t2_tie_second");
    chk("t2_tie_second_vect", o_vect_num, 5);
    do_read();
    i_dev_req = '0;

    // 3: withdraw when CPU priority rises, then re-offer
    i_curr_pri = 3'd1;
    cfg(0, 1, 2, 7);
    i_dev_req[0] = 1'b1;
    wait_offer("t3_offer");
    i_curr_pri = 3'd2;
    cyc(2);
    chk("t3_withdrawn", o_irq_pending, 0);
    chk("t3_pend_kept", o_pend[0], 1);
    i_curr_pri = 3'd1;
    wait_offer("t3_reoffer");
    chk("t3_same_vect", o_vect_num, 7);
    chk("t3_same_pri", o_irq_pri, 2);
    do_read();
    i_dev_req = '0;

    // 4: held level gives one pend; edge during ACK re-arms
    i_curr_pri = 3'd0;
    cfg(3, 1, 3, 4);
    i_dev_req[3] = 1'b1;
    wait_offer("t4_offer");
    do_read();
    cyc(4);
    chk("t4_level_no_repend", o_pend[3], 0);
    chk("t4_no_second_offer", o_irq_pending, 0);
    i_dev_req[3] = 1'b0;
    @(negedge i_clk);
    i_dev_req[3] = 1'b1;
    wait_offer("t4_offer2");
    i_dev_req[3] = 1'b0;
    i_pic_read   = 1'b1;
    @(negedge i_clk);
    i_pic_read   = 1'b0;
    i_dev_req[3] = 1'b1;
    chk("t4_ack", o_dev_ack, 8'h08);
    @(negedge i_clk);
    chk("t4_set_wins", o_pend[3], 1);
    wait_offer("t4_offer3");
    do_read();
    i_dev_req = '0;

    // 5: disabled edge discarded; priority 0 and equal priority never offered
    cfg(4, 0, 5, 1);
    i_dev_req[4] = 1'b1;
    @(negedge i_clk);
    cfg(4, 1, 5, 1);
    cyc(3);
    chk("t5_disabled_no_pend", o_pend[4], 0);
    chk("t5_disabled_no_irq", o_irq_pending, 0);
    cfg(7, 1, 0, 2);
    i_dev_req[7] = 1'b1;
    cyc(3);
    chk("t5_pri0_pend", o_pend[7], 1);
    chk("t5_pri0_no_irq", o_irq_pending, 0);
    i_curr_pri = 3'd3;
    cfg(7, 1, 3, 2);
    cyc(3);
    chk("t5_equal_no_irq", o_irq_pending, 0);
    i_curr_pri = 3'd2;
    wait_offer("t5_above_offer");
    chk("t5_vect", o_vect_num, 2);
    do_read();
    i_dev_req = '0;
    i_curr_pri = 3'd0;

    // 6: reset during OFFER beats pic_read
    @(negedge i_clk);
    i_dev_req[6] = 1'b1;
    wait_offer("t6_offer");
    i_rst      = 1'b1;
    i_pic_read = 1'b1;
    @(negedge i_clk);
    chk("t6_irq", o_irq_pending, 0);
    chk("t6_no_ack", o_dev_ack, 0);
    chk("t6_vect", o_vect_num, 0);
    chk("t6_pri", o_irq_pri, 0);
    chk("t6_pend", o_pend, 0);
    i_rst      = 1'b0;
    i_pic_read = 1'b0;
    i_dev_req  = '0;

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      i_dev_req = i_dev_req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      i_cfg_we  = ($urandom_range(0, 9) == 0);
      i_cfg_idx = 3'($urandom);
      i_cfg_en  = ($urandom_range(0, 3) != 0);
      i_cfg_pri = 3'($urandom);
      i_cfg_vect = 4'($urandom);
      if ($urandom_range(0, 19) == 0) i_curr_pri = 3'($urandom_range(0, 5));
      i_pic_read = o_irq_pending ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      i_rst = ($urandom_range(0, 499) == 0);
      @(negedge i_clk);
    end
    i_cfg_we = 1'b0;
    i_pic_read = 1'b0;
    i_rst = 1'b0;
    cyc(4);
    chk("events_left_over", ev_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
